// File: rtl/ctrl_reg_bank_pkg.sv
// ctrl_reg_pkg: shared defaults and write-mode encodings for ctrl_reg_bank.
//   DEF_WIDTH / DEF_NUM_CH / DEF_CNT_W / DEF_RESET_VAL : default parameters
//   MODE_IMM / MODE_DEF : value of IMM[i] selecting immediate / deferred write
package ctrl_reg_pkg;
    localparam int          DEF_WIDTH     = 32;
    localparam int          DEF_NUM_CH    = 4;
    localparam int          DEF_CNT_W     = 16;
    localparam logic [31:0] DEF_RESET_VAL = 32'h0000_0000;
    localparam logic        MODE_IMM      = 1'b1;
    localparam logic        MODE_DEF      = 1'b0;
endpackage

// File: rtl/ctrl_reg_bank_if.sv
// ctrl_reg_bank_if: write/commit bus of the register bank.
//   master : drives WREN, IMM, IN_VAL, COMMIT, DISCARD; observes outputs
//   slave  : the bank; drives OUT_VAL, PEND, COMMIT_CNT, ERR
interface ctrl_reg_bank_if
    import ctrl_reg_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
);
    logic [NUM_CH-1:0]       WREN;
    logic [NUM_CH-1:0]       IMM;
    logic [NUM_CH*WIDTH-1:0] IN_VAL;
    logic                    COMMIT;
    logic                    DISCARD;
    logic [NUM_CH*WIDTH-1:0] OUT_VAL;
    logic [NUM_CH-1:0]       PEND;
    logic [CNT_W-1:0]        COMMIT_CNT;
    logic                    ERR;

    modport master (
        output WREN, IMM, IN_VAL, COMMIT, DISCARD,
        input  OUT_VAL, PEND, COMMIT_CNT, ERR
    );

    modport slave (
        input  WREN, IMM, IN_VAL, COMMIT, DISCARD,
        output OUT_VAL, PEND, COMMIT_CNT, ERR
    );
endinterface

// File: rtl/ctrl_reg_bank_ch.sv
// ctrl_reg_ch: one channel of the bank (visible, shadow, pending flag).
//   clk_i, rst_i          : clock, synchronous active-high reset
//   wren_i, imm_i         : write enable and write mode
//   in_val_i              : write data
//   commit_i, discard_i   : already conflict-resolved by the top
//   vis_o, pend_o         : visible value, pending-deferred-write flag
module ctrl_reg_ch
    import ctrl_reg_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wren_i,
    input  logic             imm_i,
    input  logic [WIDTH-1:0] in_val_i,
    input  logic             commit_i,
    input  logic             discard_i,
    output logic [WIDTH-1:0] vis_o,
    output logic             pend_o
);
    logic [WIDTH-1:0] vis_q, vis_d;
    logic [WIDTH-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             imm_wr, def_wr;
    logic [WIDTH-1:0] eff_shd;
    logic             eff_pend;

    assign imm_wr   = wren_i && (imm_i == MODE_IMM);
    assign def_wr   = wren_i && (imm_i == MODE_DEF);
    // A deferred write in the same cycle as COMMIT is seen through the shadow.
    assign eff_shd  = def_wr ? in_val_i : shd_q;
    assign eff_pend = pend_q | def_wr;

    // Priority: immediate write, then discard, then commit, then plain staging.
    always_comb begin
        vis_d  = vis_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        if (imm_wr) begin
            vis_d  = in_val_i;
            shd_d  = in_val_i;
            pend_d = 1'b0;
        end else if (discard_i) begin
            shd_d  = vis_q;
            pend_d = 1'b0;
        end else if (commit_i) begin
            if (eff_pend) begin
                vis_d  = eff_shd;
                shd_d  = eff_shd;
                pend_d = 1'b0;
            end
        end else if (def_wr) begin
            shd_d  = in_val_i;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vis_q  <= RESET_VAL;
            shd_q  <= RESET_VAL;
            pend_q <= 1'b0;
        end else begin
            vis_q  <= vis_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
        end
    end

    assign vis_o  = vis_q;
    assign pend_o = pend_q;
endmodule

// File: rtl/ctrl_reg_bank.sv
// ctrl_reg_bank: NUM_CH datapath registers with shadow/commit staging.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : ctrl_reg_bank_if slave (writes, COMMIT/DISCARD, outputs)
// Owns the commit counter, the conflict error pulse and COMMIT/DISCARD
// resolution (DISCARD wins when both are asserted).
module ctrl_reg_bank
    import ctrl_reg_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               NUM_CH    = DEF_NUM_CH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL),
    parameter int               CNT_W     = DEF_CNT_W
) (
    input logic             CLK,
    input logic             RST,
    ctrl_reg_bank_if.slave  bus
);
    logic                    commit_ok;
    logic                    conflict;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [NUM_CH*WIDTH-1:0] out_val;
    logic [NUM_CH-1:0]       pend;

    assign conflict  = bus.COMMIT & bus.DISCARD;
    assign commit_ok = bus.COMMIT & ~bus.DISCARD;

    always_comb begin
        cnt_d = cnt_q;
        if (commit_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        err_d = conflict;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ctrl_reg_ch #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_ch (
            .clk_i     (CLK),
            .rst_i     (RST),
            .wren_i    (bus.WREN[i]),
            .imm_i     (bus.IMM[i]),
            .in_val_i  (bus.IN_VAL[i*WIDTH +: WIDTH]),
            .commit_i  (commit_ok),
            .discard_i (bus.DISCARD),
            .vis_o     (out_val[i*WIDTH +: WIDTH]),
            .pend_o    (pend[i])
        );
    end

    assign bus.OUT_VAL    = out_val;
    assign bus.PEND       = pend;
    assign bus.COMMIT_CNT = cnt_q;
    assign bus.ERR        = err_q;
endmodule

// File: tb/tb_ctrl_reg_bank.sv
module tb_ctrl_reg_bank;
    localparam int          W    = 32;
    localparam int          N    = 4;
    localparam int          CW   = 4;
    localparam logic [31:0] RVAL = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ctrl_reg_bank_if #(.WIDTH(W), .NUM_CH(N), .CNT_W(CW)) bus ();

    ctrl_reg_bank #(
        .WIDTH(W), .NUM_CH(N), .RESET_VAL(RVAL), .CNT_W(CW)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Reference model state, one entry per channel.
    logic [31:0] m_vis  [N];
    logic [31:0] m_shd  [N];
    logic        m_pend [N];
    int          m_cnt;
    logic        m_err;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge, from the operating rules of the bank.
    task automatic model_step();
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_vis[i] = RVAL; m_shd[i] = RVAL; m_pend[i] = 1'b0;
            end
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                logic [31:0] d;
                logic        is_imm, is_def, pend_now;
                d        = bus.IN_VAL[i*W +: W];
                is_imm   = bus.WREN[i] & bus.IMM[i];
                is_def   = bus.WREN[i] & ~bus.IMM[i];
                pend_now = m_pend[i] | is_def;
                if (is_imm) begin
                    m_vis[i] = d; m_shd[i] = d; m_pend[i] = 1'b0;
                end else if (bus.DISCARD) begin
                    m_shd[i] = m_vis[i]; m_pend[i] = 1'b0;
                end else if (bus.COMMIT) begin
                    if (pend_now) begin
                        m_vis[i]  = is_def ? d : m_shd[i];
                        m_shd[i]  = m_vis[i];
                        m_pend[i] = 1'b0;
                    end
                end else if (is_def) begin
                    m_shd[i] = d; m_pend[i] = 1'b1;
                end
            end
            m_err = bus.COMMIT & bus.DISCARD;
            if (bus.COMMIT && !bus.DISCARD) m_cnt = (m_cnt + 1) % (1 << CW);
        end
    endtask

    task automatic check_all();
        logic [31:0] pexp;
        pexp = '0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("out%0d", i), bus.OUT_VAL[i*W +: W], m_vis[i]);
            pexp[i] = m_pend[i];
        end
        chk("pend", 32'(bus.PEND), pexp);
        chk("cnt", 32'(bus.COMMIT_CNT), 32'(m_cnt));
        chk("err", 32'(bus.ERR), 32'(m_err));
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic cyc(input logic [N-1:0] wren, input logic [N-1:0] imm,
                       input logic [N*W-1:0] vals, input logic commit,
                       input logic discard, input logic r);
        bus.WREN = wren; bus.IMM = imm; bus.IN_VAL = vals;
        bus.COMMIT = commit; bus.DISCARD = discard; rst = r;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    function automatic logic [N*W-1:0] at(input int ch, input logic [31:0] v);
        logic [N*W-1:0] r;
        r = '0;
        r[ch*W +: W] = v;
        return r;
    endfunction

    task automatic idle();
        cyc('0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.WREN = '0; bus.IMM = '0; bus.IN_VAL = '0;
        bus.COMMIT = 1'b0; bus.DISCARD = 1'b0; rst = 1'b1;

        // Reset for two cycles.
        cyc('0, '0, '0, 1'b0, 1'b0, 1'b1);
        cyc('0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) chk("rst_out", bus.OUT_VAL[i*W +: W], 32'h1000);
        chk("rst_pend", 32'(bus.PEND), 32'h0);
        chk("rst_cnt", 32'(bus.COMMIT_CNT), 32'h0);

        // Immediate, then deferred, then commit on channel 0.
        cyc(4'b0001, 4'b0001, at(0, 32'hAAAA_0001), 1'b0, 1'b0, 1'b0);
        chk("imm_out0", bus.OUT_VAL[31:0], 32'hAAAA_0001);
        cyc(4'b0001, 4'b0000, at(0, 32'h5555), 1'b0, 1'b0, 1'b0);
        chk("def_pend0", 32'(bus.PEND[0]), 32'h1);
        chk("def_out0", bus.OUT_VAL[31:0], 32'hAAAA_0001);
        cyc('0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("cmt_out0", bus.OUT_VAL[31:0], 32'h5555);
        chk("cmt_cnt", 32'(bus.COMMIT_CNT), 32'h1);

        // Multi-channel atomic commit with a write-through on channel 3.
        cyc(4'b0010, 4'b0000, at(1, 32'h11), 1'b0, 1'b0, 1'b0);
        cyc(4'b0100, 4'b0000, at(2, 32'h22), 1'b0, 1'b0, 1'b0);
        chk("stage_out1", bus.OUT_VAL[63:32], 32'h1000);
        cyc(4'b1000, 4'b0000, at(3, 32'h33), 1'b1, 1'b0, 1'b0);
        chk("atom_out1", bus.OUT_VAL[63:32], 32'h11);
        chk("atom_out2", bus.OUT_VAL[95:64], 32'h22);
        chk("atom_out3", bus.OUT_VAL[127:96], 32'h33);
        chk("atom_pend", 32'(bus.PEND), 32'h0);

        // Conflict: COMMIT and DISCARD together discard, pulse ERR once.
        cyc(4'b0010, 4'b0000, at(1, 32'h77), 1'b0, 1'b0, 1'b0);
        cyc('0, '0, '0, 1'b1, 1'b1, 1'b0);
        chk("cfl_out1", bus.OUT_VAL[63:32], 32'h11);
        chk("cfl_err", 32'(bus.ERR), 32'h1);
        chk("cfl_cnt", 32'(bus.COMMIT_CNT), 32'h2);
        idle();
        chk("cfl_err_drop", 32'(bus.ERR), 32'h0);

        // Immediate overrides a pending deferred write.
        cyc(4'b0100, 4'b0000, at(2, 32'h99), 1'b0, 1'b0, 1'b0);
        cyc(4'b0100, 4'b0100, at(2, 32'h44), 1'b0, 1'b0, 1'b0);
        chk("ovr_out2", bus.OUT_VAL[95:64], 32'h44);
        cyc('0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("ovr_cmt_out2", bus.OUT_VAL[95:64], 32'h44);

        // Reset drops pending data.
        cyc(4'b0001, 4'b0000, at(0, 32'hDEAD), 1'b0, 1'b0, 1'b0);
        cyc('0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("rst2_out0", bus.OUT_VAL[31:0], 32'h1000);
        chk("rst2_pend", 32'(bus.PEND), 32'h0);

        // 17 commits wrap a 4-bit counter to 1.
        for (int k = 0; k < 17; k++) cyc('0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("wrap_cnt", 32'(bus.COMMIT_CNT), 32'h1);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            logic [N*W-1:0] v;
            for (int i = 0; i < N; i++) v[i*W +: W] = $urandom;
            cyc(N'($urandom), N'($urandom), v,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 49) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
